// File: rtl/morra_cinese_param.sv
// morra_cinese_param -- rock/paper/scissors ("morra cinese") match referee.
//
// A configuration pulse on INIZIA loads the game length
// (MIN_MANCHE + {PRIMO,SECONDO}) and starts a partita. While playing, every
// clock cycle with INIZIA low is one manche attempt. The partita ends early
// when, after at least MIN_MANCHE counted manches, one player leads by LEAD
// wins. Otherwise it ends when the manche limit is reached.
//
// Optional feature (macro MORRA_MOVE_LOCK_EN): the move lock. The winner of a
// manche may not repeat the winning move on the next attempt. The loser's
// lock is cleared. A tie clears both locks.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   INIZIA     start/configure; has priority over moves
//   PRIMO      player 1 move (00 none, 01 sasso, 10 carta, 11 forbice);
//              config bits [3:2] during INIZIA
//   SECONDO    player 2 move, same encoding; config bits [1:0] during INIZIA
//   MANCHE     registered manche result (00 none, 01 P1, 10 P2, 11 tie)
//   PARTITA    registered game result (00 running/idle, 01 P1, 10 P2, 11 draw)
//   state_dbg  current FSM state (00 IDLE, 01 PLAY, 10 DONE)
//
// Handshake: there is no valid/ready pair. Inputs are sampled on every rising
// edge. MANCHE is a one-cycle registered result of the attempt sampled on the
// previous edge. PARTITA is sticky until the next INIZIA or rst.
module morra_cinese_param #(
  parameter int unsigned MIN_MANCHE = 4,
  parameter int unsigned LEAD       = 2,
  parameter int unsigned CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       INIZIA,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MANCHE);
  localparam logic [CNT_W-1:0] LEAD_C = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] max_manche;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wins1;
  logic [CNT_W-1:0] wins2;
`ifdef MORRA_MOVE_LOCK_EN
  logic [1:0]       lock1;
  logic [1:0]       lock2;
`endif

  logic             valid;
  logic             tie;
  logic             p1_win;
  logic             p2_win;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] w1_nx;
  logic [CNT_W-1:0] w2_nx;
  logic [CNT_W-1:0] diff;
  logic             lead_hit;
  logic             limit_hit;

  always_comb begin
    valid = (PRIMO != 2'b00) && (SECONDO != 2'b00);
`ifdef MORRA_MOVE_LOCK_EN
    // Locks hold 00 when inactive, and 00 never matches a nonzero move.
    valid = valid && (PRIMO != lock1) && (SECONDO != lock2);
`endif
    tie    = (PRIMO == SECONDO);
    p1_win = ((PRIMO == 2'b01) && (SECONDO == 2'b11)) ||
             ((PRIMO == 2'b10) && (SECONDO == 2'b01)) ||
             ((PRIMO == 2'b11) && (SECONDO == 2'b10));
    p2_win = !tie && !p1_win;
    cnt_nx = count + ONE_C;
    w1_nx  = p1_win ? (wins1 + ONE_C) : wins1;
    w2_nx  = p2_win ? (wins2 + ONE_C) : wins2;
    // Magnitude is formed larger-minus-smaller, so it never wraps.
    diff      = (w1_nx >= w2_nx) ? (w1_nx - w2_nx) : (w2_nx - w1_nx);
    lead_hit  = (cnt_nx >= MIN_C) && (diff >= LEAD_C);
    limit_hit = (cnt_nx == max_manche);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      max_manche <= MIN_C;
      count      <= '0;
      wins1      <= '0;
      wins2      <= '0;
`ifdef MORRA_MOVE_LOCK_EN
      lock1      <= 2'b00;
      lock2      <= 2'b00;
`endif
      MANCHE     <= 2'b00;
      PARTITA    <= 2'b00;
    end else if (INIZIA) begin
      state      <= PLAY;
      max_manche <= MIN_C + CNT_W'({PRIMO, SECONDO});
      count      <= '0;
      wins1      <= '0;
      wins2      <= '0;
`ifdef MORRA_MOVE_LOCK_EN
      lock1      <= 2'b00;
      lock2      <= 2'b00;
`endif
      MANCHE     <= 2'b00;
      PARTITA    <= 2'b00;
    end else begin
      case (state)
        PLAY: begin
          if (valid) begin
            count <= cnt_nx;
            wins1 <= w1_nx;
            wins2 <= w2_nx;
            if (tie) begin
              MANCHE <= 2'b11;
`ifdef MORRA_MOVE_LOCK_EN
              lock1  <= 2'b00;
              lock2  <= 2'b00;
`endif
            end else if (p1_win) begin
              MANCHE <= 2'b01;
`ifdef MORRA_MOVE_LOCK_EN
              lock1  <= PRIMO;
              lock2  <= 2'b00;
`endif
            end else begin
              MANCHE <= 2'b10;
`ifdef MORRA_MOVE_LOCK_EN
              lock1  <= 2'b00;
              lock2  <= SECONDO;
`endif
            end
            if (lead_hit) begin
              PARTITA <= (w1_nx > w2_nx) ? 2'b01 : 2'b10;
              state   <= DONE;
            end else if (limit_hit) begin
              if (w1_nx > w2_nx)      PARTITA <= 2'b01;
              else if (w2_nx > w1_nx) PARTITA <= 2'b10;
              else                    PARTITA <= 2'b11;
              state <= DONE;
            end
          end else begin
            MANCHE <= 2'b00;
          end
        end
        default: begin
          // IDLE and DONE ignore moves. PARTITA holds its value.
          MANCHE <= 2'b00;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_morra_cinese_param.sv
// tb_morra_cinese_param -- scoreboard bench for morra_cinese_param.
// A driver applies one input set per cycle and pushes the expected
// {state, MANCHE, PARTITA} into exp_q. A monitor pops and compares on every
// falling edge. The reference model uses modular arithmetic on move values to
// decide manche winners and plain integers for the game bookkeeping.
module tb_morra_cinese_param;

  localparam int MIN_MANCHE = 4;
  localparam int LEAD       = 2;
  localparam int CNT_W      = 5;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic       clk;
  logic       rst;
  logic       INIZIA;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;
  logic [1:0] state_dbg;

  morra_cinese_param #(
    .MIN_MANCHE(MIN_MANCHE),
    .LEAD      (LEAD),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .INIZIA   (INIZIA),
    .PRIMO    (PRIMO),
    .SECONDO  (SECONDO),
    .MANCHE   (MANCHE),
    .PARTITA  (PARTITA),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {st,manche,partita}=%b required %b", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      logic [5:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {state_dbg, MANCHE, PARTITA}, e);
    end
  end

  // ---------------- reference model ----------------
  int m_phase;  // 0 idle, 1 play, 2 done
  int m_cnt, m_w1, m_w2, m_max, m_l1, m_l2, m_part;

  // 0 tie, 1 player 1, 2 player 2. Moves 1..3 form a cycle where each value
  // beats the one below it modulo 3.
  function automatic int winner(input int a, input int b);
    if (a == b) return 0;
    if ((a - b + 3) % 3 == 1) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_w1 = 0; m_w2 = 0;
    m_max = MIN_MANCHE; m_l1 = 0; m_l2 = 0; m_part = 0;
  endtask

  task automatic model_step(input logic ini, input logic [1:0] p, input logic [1:0] s,
                            output logic [5:0] e);
    int m;
    int pi;
    int si;
    int r;
    int d;
    bit ok;
    m  = 0;
    pi = int'(p);
    si = int'(s);
    if (ini) begin
      m_max = MIN_MANCHE + int'({p, s});
      m_cnt = 0; m_w1 = 0; m_w2 = 0; m_l1 = 0; m_l2 = 0; m_part = 0;
      m_phase = 1;
    end else if (m_phase == 1) begin
      ok = (pi != 0) && (si != 0);
`ifdef MORRA_MOVE_LOCK_EN
      ok = ok && (pi != m_l1) && (si != m_l2);
`endif
      if (ok) begin
        m_cnt++;
        r = winner(pi, si);
        if (r == 0) begin m = 3; m_l1 = 0;  m_l2 = 0;  end
        else if (r == 1) begin m = 1; m_w1++; m_l1 = pi; m_l2 = 0; end
        else begin m = 2; m_w2++; m_l1 = 0; m_l2 = si; end
        d = (m_w1 > m_w2) ? m_w1 - m_w2 : m_w2 - m_w1;
        if (m_cnt >= MIN_MANCHE && d >= LEAD) begin
          m_part = (m_w1 > m_w2) ? 1 : 2;
          m_phase = 2;
        end else if (m_cnt == m_max) begin
          m_part = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
          m_phase = 2;
        end
      end
    end
    e = {2'(m_phase), 2'(m), 2'(m_part)};
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic ini, input logic [1:0] p, input logic [1:0] s,
                      input string tag);
    logic [5:0] e;
    INIZIA = ini; PRIMO = p; SECONDO = s;
    model_step(ini, p, s, e);
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
  endtask

  // Directed step: the required outcome is given literally; the model is
  // still advanced so later random traffic stays in sync.
  task automatic step_req(input logic ini, input logic [1:0] p, input logic [1:0] s,
                          input logic [1:0] st, input logic [1:0] m, input logic [1:0] pt,
                          input string tag);
    logic [5:0] e;
    INIZIA = ini; PRIMO = p; SECONDO = s;
    model_step(ini, p, s, e);
    @(posedge clk);
    exp_q.push_back({st, m, pt});
    tag_q.push_back(tag);
    #1;
  endtask

  function automatic logic [1:0] rnd_move();
    if ($urandom_range(0, 7) == 0) return 2'b00;
    return 2'($urandom_range(1, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; INIZIA = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
    model_reset();
    #1;
    chk("reset_state", {state_dbg, MANCHE, PARTITA}, 6'b000000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // moves before any INIZIA are ignored
    step_req(0, 2'b01, 2'b11, S_IDLE, 2'b00, 2'b00, "idle_ignore");

    // win by lead
    step_req(1, 2'b00, 2'b00, S_PLAY, 2'b00, 2'b00, "lead_init");
    step_req(0, 2'b01, 2'b11, S_PLAY, 2'b01, 2'b00, "lead_m1");
    step_req(0, 2'b10, 2'b01, S_PLAY, 2'b01, 2'b00, "lead_m2");
    step_req(0, 2'b11, 2'b10, S_PLAY, 2'b01, 2'b00, "lead_m3");
    step_req(0, 2'b01, 2'b01, S_DONE, 2'b11, 2'b01, "lead_m4");
    step_req(0, 2'b01, 2'b11, S_DONE, 2'b00, 2'b01, "lead_done_hold");

    // lock rule
    step_req(1, 2'b00, 2'b00, S_PLAY, 2'b00, 2'b00, "lock_init");
    step_req(0, 2'b01, 2'b11, S_PLAY, 2'b01, 2'b00, "lock_m1");
`ifdef MORRA_MOVE_LOCK_EN
    step_req(0, 2'b01, 2'b10, S_PLAY, 2'b00, 2'b00, "lock_repeat");
`else
    step_req(0, 2'b01, 2'b10, S_PLAY, 2'b10, 2'b00, "nolock_repeat");
`endif

`ifndef MORRA_MOVE_LOCK_EN
    // draw at the limit
    step_req(1, 2'b00, 2'b00, S_PLAY, 2'b00, 2'b00, "draw_init");
    step_req(0, 2'b01, 2'b11, S_PLAY, 2'b01, 2'b00, "draw_m1");
    step_req(0, 2'b11, 2'b01, S_PLAY, 2'b10, 2'b00, "draw_m2");
    step_req(0, 2'b10, 2'b01, S_PLAY, 2'b01, 2'b00, "draw_m3");
    step_req(0, 2'b01, 2'b10, S_DONE, 2'b10, 2'b11, "draw_m4");
    step_req(0, 2'b10, 2'b01, S_DONE, 2'b00, 2'b11, "draw_done_hold");
`endif

    // extended limit: max 19
    step_req(1, 2'b11, 2'b11, S_PLAY, 2'b00, 2'b00, "ext_init");
    for (int i = 0; i < 9; i++) begin
      step_req(0, 2'b01, 2'b11, S_PLAY, 2'b01, 2'b00, "ext_p1");
      step_req(0, 2'b11, 2'b01, S_PLAY, 2'b10, 2'b00, "ext_p2");
    end
    step_req(0, 2'b10, 2'b10, S_DONE, 2'b11, 2'b11, "ext_m19");

    // asynchronous reset mid-game
    step_req(1, 2'b00, 2'b00, S_PLAY, 2'b00, 2'b00, "arst_init");
    step_req(0, 2'b01, 2'b11, S_PLAY, 2'b01, 2'b00, "arst_m1");
    step_req(0, 2'b11, 2'b01, S_PLAY, 2'b10, 2'b00, "arst_m2");
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("arst_immediate", {state_dbg, MANCHE, PARTITA}, 6'b000000);
    #1 rst = 1'b0;
    model_reset();
    step_req(0, 2'b01, 2'b11, S_IDLE, 2'b00, 2'b00, "arst_ignore1");
    step_req(0, 2'b10, 2'b01, S_IDLE, 2'b00, 2'b00, "arst_ignore2");

    // invalid move and INIZIA priority
    step_req(1, 2'b00, 2'b00, S_PLAY, 2'b00, 2'b00, "inv_init");
    step_req(0, 2'b00, 2'b01, S_PLAY, 2'b00, 2'b00, "inv_zero_move");
    step_req(1, 2'b01, 2'b11, S_PLAY, 2'b00, 2'b00, "prio_inizia");
    step(0, 2'b01, 2'b11, "prio_after");

    // randomized games against the model
    for (int g = 0; g < 40; g++) begin
      logic [3:0] cfg;
      cfg = 4'($urandom_range(0, 15));
      step(1, cfg[3:2], cfg[1:0], "rnd_init");
      for (int c = 0; c < MIN_MANCHE + 20; c++) begin
        logic ini;
        ini = ($urandom_range(0, 39) == 0);
        step(ini, rnd_move(), rnd_move(), "rnd_play");
      end
    end

    // drain the scoreboard with a bounded wait
    INIZIA = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
